// File: rtl/button_event_parser.sv
// Button front end: per-channel synchroniser, tick-driven debounce, registered level/press/release
// pulses and a per-channel auto-repeat event stream. release/event are reserved words, hence *_pulse.
module button_event_parser #(
  parameter int WIDTH            = 7,
  parameter int SYNC_STAGES      = 2,
  parameter int SAMPLE_COUNT_MAX = 38000,
  parameter int PULSE_COUNT_MAX  = 150,
  parameter int REPEAT_DELAY     = 650,
  parameter int REPEAT_RATE      = 130
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] repeat_en,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] press,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] event_pulse
);

  localparam int SC_W    = $clog2(SAMPLE_COUNT_MAX + 1);
  localparam int DB_W    = $clog2(PULSE_COUNT_MAX + 1);
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RC_W    = $clog2(REP_MAX + 1);

  localparam logic [SC_W-1:0] SC_LAST = SC_W'(SAMPLE_COUNT_MAX - 1);
  localparam logic [DB_W-1:0] DB_MAX  = DB_W'(PULSE_COUNT_MAX);
  localparam logic [RC_W-1:0] REP_D   = RC_W'(REPEAT_DELAY);
  localparam logic [RC_W-1:0] REP_R   = RC_W'(REPEAT_RATE);

  typedef enum logic [1:0] {IDLE, DELAY, RATE} rep_state_t;

  function automatic logic [DB_W-1:0] sat_inc(input logic [DB_W-1:0] v);
    return (v == DB_MAX) ? v : v + DB_W'(1);
  endfunction

  // Stage p0: synchroniser chain
  logic [WIDTH-1:0] sync_p0 [SYNC_STAGES];
  logic [WIDTH-1:0] s;

  assign s = sync_p0[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_p0[k] <= '0;
    end else begin
      sync_p0[0] <= in;
      for (int k = 1; k < SYNC_STAGES; k++) sync_p0[k] <= sync_p0[k-1];
    end
  end

  // Stage p1: sample tick, debounce counters and repeat FSMs
  logic [SC_W-1:0]  sample_cnt_p1;
  logic             tick;
  logic [DB_W-1:0]  db_cnt_p1 [WIDTH];
  logic [DB_W-1:0]  db_next   [WIDTH];
  rep_state_t       rep_state_p1 [WIDTH];
  logic [RC_W-1:0]  rep_cnt_p1 [WIDTH];
  logic [RC_W-1:0]  rep_inc    [WIDTH];
  logic [WIDTH-1:0] rep_p1;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] d_next;

  assign tick = (sample_cnt_p1 == SC_LAST);

  always_ff @(posedge clk) begin
    if (rst || tick) sample_cnt_p1 <= '0;
    else             sample_cnt_p1 <= sample_cnt_p1 + SC_W'(1);
  end

  // The FSM acts on the tick that moves d, so it looks at the counter's next value.
  always_comb begin
    d      = '0;
    d_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      db_next[i] = db_cnt_p1[i];
      if (tick) db_next[i] = s[i] ? sat_inc(db_cnt_p1[i]) : '0;
      d[i]       = (db_cnt_p1[i] == DB_MAX);
      d_next[i]  = (db_next[i] == DB_MAX);
      rep_inc[i] = rep_cnt_p1[i] + RC_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rep_p1 <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        db_cnt_p1[i]    <= '0;
        rep_state_p1[i] <= IDLE;
        rep_cnt_p1[i]   <= '0;
      end
    end else begin
      rep_p1 <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        db_cnt_p1[i] <= db_next[i];
        if (tick) begin
          if (!d_next[i]) begin
            rep_state_p1[i] <= IDLE;
            rep_cnt_p1[i]   <= '0;
          end else begin
            case (rep_state_p1[i])
              IDLE: begin
                rep_state_p1[i] <= DELAY;
                rep_cnt_p1[i]   <= '0;
              end
              DELAY: begin
                if (rep_inc[i] == REP_D) begin
                  rep_p1[i]       <= 1'b1;
                  rep_cnt_p1[i]   <= '0;
                  rep_state_p1[i] <= RATE;
                end else begin
                  rep_cnt_p1[i] <= rep_inc[i];
                end
              end
              RATE: begin
                if (rep_inc[i] == REP_R) begin
                  rep_p1[i]     <= 1'b1;
                  rep_cnt_p1[i] <= '0;
                end else begin
                  rep_cnt_p1[i] <= rep_inc[i];
                end
              end
              default: begin
                rep_state_p1[i] <= IDLE;
                rep_cnt_p1[i]   <= '0;
              end
            endcase
          end
        end
      end
    end
  end

  // Stage p2: registered outputs; level doubles as the previous debounced value
  always_ff @(posedge clk) begin
    if (rst) begin
      level         <= '0;
      press         <= '0;
      release_pulse <= '0;
      event_pulse   <= '0;
    end else begin
      level         <= d;
      press         <= d & ~level;
      release_pulse <= ~d & level;
      event_pulse   <= (d & ~level) | (rep_p1 & repeat_en);
    end
  end

endmodule
